decode_stage: RTL and testbench

DECODE_STAGE -- requirements
Module: decode_stage

---
 rtl/cpu_pkg.sv | 89 ++++++++
 rtl/decode_scoreboard.sv | 38 +++
 rtl/decode_stage.sv | 117 +++++++++++
 tb/tb_decode_stage.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: instruction field positions, register-address width,
// opcode constants and the combinational instruction decoder used by the decode
// stage.
package cpu_pkg;

  localparam int unsigned InstrW   = 16;
  localparam int unsigned RegAddrW = 4;
  localparam int unsigned NumRegs  = 1 << RegAddrW;
  localparam int unsigned OpcodeW  = 4;
  localparam int unsigned ImmW     = 16;
  localparam int unsigned Imm8W    = 8;

  // Field positions (LSB of each field) within an instruction word
  localparam int unsigned OpcodeLsb = 12;
  localparam int unsigned RdLsb     = 8;
  localparam int unsigned RsLsb     = 4;
  localparam int unsigned RtLsb     = 0;
  localparam int unsigned Imm8Lsb   = 0;

  localparam logic [OpcodeW-1:0] OpNop      = 4'h0;
  localparam logic [OpcodeW-1:0] OpAluFirst = 4'h1;
  localparam logic [OpcodeW-1:0] OpAluLast  = 4'h7;
  localparam logic [OpcodeW-1:0] OpLoadi    = 4'h8;
  localparam logic [OpcodeW-1:0] OpLoad     = 4'h9;
  localparam logic [OpcodeW-1:0] OpStore    = 4'hA;
  localparam logic [OpcodeW-1:0] OpBeq      = 4'hB;
  localparam logic [OpcodeW-1:0] OpJump     = 4'hC;

  typedef struct packed {
    logic [OpcodeW-1:0]  opcode;
    logic [RegAddrW-1:0] rd;
    logic                writes;   // instruction writes rd
    logic                illegal;  // opcode 0xD-0xF
    logic [RegAddrW-1:0] src1;     // zero when unused
    logic                src1_en;
    logic [RegAddrW-1:0] src2;     // zero when unused
    logic                src2_en;
    logic [ImmW-1:0]     imm;
  } dec_t;

  function automatic dec_t decode_instr(input logic [InstrW-1:0] instr);
    dec_t                d;
    logic [OpcodeW-1:0]  op;
    logic [RegAddrW-1:0] rd;
    logic [RegAddrW-1:0] rs;
    logic [RegAddrW-1:0] rt;
    logic [Imm8W-1:0]    imm8;
    op   = instr[OpcodeLsb +: OpcodeW];
    rd   = instr[RdLsb +: RegAddrW];
    rs   = instr[RsLsb +: RegAddrW];
    rt   = instr[RtLsb +: RegAddrW];
    imm8 = instr[Imm8Lsb +: Imm8W];
    d        = '0;
    d.opcode = op;
    d.rd     = rd;
    if (op >= OpAluFirst && op <= OpAluLast) begin
      d.src1    = rs;
      d.src1_en = 1'b1;
      d.src2    = rt;
      d.src2_en = 1'b1;
      d.writes  = 1'b1;
    end else begin
      case (op)
        OpNop: ;
        OpLoadi: begin
          d.writes = 1'b1;
          d.imm    = {{(ImmW - Imm8W){1'b0}}, imm8};
        end
        OpLoad: begin
          d.src1    = rs;
          d.src1_en = 1'b1;
          d.writes  = 1'b1;
        end
        OpStore, OpBeq: begin
          // Compare/store forms read rd as the first operand
          d.src1    = rd;
          d.src1_en = 1'b1;
          d.src2    = rs;
          d.src2_en = 1'b1;
          if (op == OpBeq) d.imm = {{(ImmW - Imm8W){imm8[Imm8W-1]}}, imm8};
        end
        OpJump: d.imm = {{(ImmW - RegAddrW - Imm8W){1'b0}}, rd, imm8};
        default: d.illegal = 1'b1;
      endcase
    end
    return d;
  endfunction

endpackage

// File: rtl/decode_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set when a
// writing instruction is accepted and cleared on writeback or flush.
// Ports:
//   clock, reset      - clock, synchronous active-high reset
//   i_set_en/i_set_reg - mark a register as having a write in flight
//   i_clr_mask        - registers whose pending write is retired/cancelled
//   i_query_mask      - registers the incoming instruction touches
//   o_hazard          - any queried register is pending
module decode_scoreboard import cpu_pkg::*; (
  input  logic                clock,
  input  logic                reset,
  input  logic                i_set_en,
  input  logic [RegAddrW-1:0] i_set_reg,
  input  logic [NumRegs-1:0]  i_clr_mask,
  input  logic [NumRegs-1:0]  i_query_mask,
  output logic                o_hazard
);

  logic [NumRegs-1:0] r_pending;
  logic [NumRegs-1:0] w_set_mask;

  always_comb begin
    w_set_mask = '0;
    if (i_set_en) w_set_mask[i_set_reg] = 1'b1;
  end

  // Set is applied after clear so a same-cycle set/clear leaves the bit set
  always_ff @(posedge clock) begin
    if (reset) begin
      r_pending <= '0;
    end else begin
      r_pending <= (r_pending & ~i_clr_mask) | w_set_mask;
    end
  end

  assign o_hazard = |(r_pending & i_query_mask);

endmodule

// File: rtl/decode_stage.sv
// Instruction decode stage: decodes a 16-bit instruction from fetch, holds the
// decoded result in a single output register toward execute, and stalls on
// RAW/WAW hazards against in-flight writes.
// Build option: define DECODE_SCOREBOARD_EN to enable the pending-write
// scoreboard; without it hazard is never raised and wb_valid/wb_reg are ignored.
// Ports:
//   clock, reset                 - clock, synchronous active-high reset
//   in_valid/in_ready/in_instr   - fetch handshake and instruction
//   out_valid/out_ready          - execute handshake
//   readReg1/readReg2            - register-file read addresses (combinational)
//   writeReg/out_reg_write/out_opcode/out_imm - registered decoded fields
//   wb_valid/wb_reg              - writeback completion notice
//   flush                        - discard the held instruction
//   illegal                      - one-cycle pulse after accepting 0xD-0xF
module decode_stage import cpu_pkg::*; (
  input  logic                clock,
  input  logic                reset,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [InstrW-1:0]   in_instr,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [RegAddrW-1:0] readReg1,
  output logic [RegAddrW-1:0] readReg2,
  output logic [RegAddrW-1:0] writeReg,
  output logic                out_reg_write,
  output logic [OpcodeW-1:0]  out_opcode,
  output logic [ImmW-1:0]     out_imm,
  input  logic                wb_valid,
  input  logic [RegAddrW-1:0] wb_reg,
  input  logic                flush,
  output logic                illegal
);

  dec_t w_dec;
  logic w_hazard;
  logic w_accept;

  logic                r_out_valid;
  logic [RegAddrW-1:0] r_write_reg;
  logic                r_reg_write;
  logic [OpcodeW-1:0]  r_opcode;
  logic [ImmW-1:0]     r_imm;
  logic                r_illegal;

  assign w_dec    = decode_instr(in_instr);
  assign readReg1 = w_dec.src1;
  assign readReg2 = w_dec.src2;

`ifdef DECODE_SCOREBOARD_EN
  logic [NumRegs-1:0] w_query_mask;
  logic [NumRegs-1:0] w_clr_mask;

  always_comb begin
    w_query_mask = '0;
    if (w_dec.src1_en) w_query_mask[w_dec.src1] = 1'b1;
    if (w_dec.src2_en) w_query_mask[w_dec.src2] = 1'b1;
    if (w_dec.writes)  w_query_mask[w_dec.rd]   = 1'b1;
  end

  // A flushed writer never reaches writeback, so its pending bit is dropped here
  always_comb begin
    w_clr_mask = '0;
    if (wb_valid) w_clr_mask[wb_reg] = 1'b1;
    if (flush && r_out_valid && r_reg_write) w_clr_mask[r_write_reg] = 1'b1;
  end

  decode_scoreboard u_scoreboard (
    .clock        (clock),
    .reset        (reset),
    .i_set_en     (w_accept && w_dec.writes),
    .i_set_reg    (w_dec.rd),
    .i_clr_mask   (w_clr_mask),
    .i_query_mask (w_query_mask),
    .o_hazard     (w_hazard)
  );
`else
  logic w_wb_unused;
  assign w_wb_unused = ^{wb_valid, wb_reg};
  assign w_hazard    = 1'b0;
`endif

  assign in_ready = !reset && (!r_out_valid || out_ready) && !w_hazard && !flush;
  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_out_valid <= 1'b0;
      r_write_reg <= '0;
      r_reg_write <= 1'b0;
      r_opcode    <= '0;
      r_imm       <= '0;
      r_illegal   <= 1'b0;
    end else begin
      r_illegal <= w_accept && w_dec.illegal;
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_accept) begin
        r_out_valid <= 1'b1;
        r_write_reg <= w_dec.rd;
        r_reg_write <= w_dec.writes;
        r_opcode    <= w_dec.opcode;
        r_imm       <= w_dec.imm;
      end else if (out_ready) begin
        r_out_valid <= 1'b0;
      end
    end
  end

  assign out_valid     = r_out_valid;
  assign writeReg      = r_write_reg;
  assign out_reg_write = r_reg_write;
  assign out_opcode    = r_opcode;
  assign out_imm       = r_imm;
  assign illegal       = r_illegal;

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// behavioural model of the stage.
module tb_decode_stage;

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic        wb_valid = 1'b0;
  logic        flush = 1'b0;
  logic [15:0] in_instr = 16'h0;
  logic [3:0]  wb_reg = 4'h0;
  logic        in_ready, out_valid, out_reg_write, illegal;
  logic [3:0]  readReg1, readReg2, writeReg, out_opcode;
  logic [15:0] out_imm;

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

`ifdef DECODE_SCOREBOARD_EN
  localparam bit SbOn = 1'b1;
`else
  localparam bit SbOn = 1'b0;
`endif

  // Model state
  bit          exp_valid, exp_rw, exp_ill;
  logic [3:0]  exp_wreg, exp_op;
  logic [15:0] exp_imm;
  bit   [15:0] pend;

  decode_stage dut (
    .clock         (clock),
    .reset         (reset),
    .in_valid      (in_valid),
    .in_ready      (in_ready),
    .in_instr      (in_instr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .readReg1      (readReg1),
    .readReg2      (readReg2),
    .writeReg      (writeReg),
    .out_reg_write (out_reg_write),
    .out_opcode    (out_opcode),
    .out_imm       (out_imm),
    .wb_valid      (wb_valid),
    .wb_reg        (wb_reg),
    .flush         (flush),
    .illegal       (illegal)
  );

  always #5 clock = ~clock;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Instruction semantics straight from the opcode table
  function automatic void spec(input logic [15:0] ins, output bit wr, output bit ill,
                               output logic [3:0] a1, output logic [3:0] a2,
                               output logic [15:0] imm, output logic [15:0] uses);
    int op = int'(ins[15:12]);
    int rd = int'(ins[11:8]);
    int rs = int'(ins[7:4]);
    int rt = int'(ins[3:0]);
    int i8 = int'(ins[7:0]);
    wr = 0; ill = 0; a1 = 0; a2 = 0; imm = 0; uses = 0;
    if (op >= 1 && op <= 7) begin
      a1 = 4'(rs); a2 = 4'(rt); wr = 1;
      uses[rs] = 1; uses[rt] = 1; uses[rd] = 1;
    end else if (op == 8) begin
      wr = 1; imm = 16'(i8); uses[rd] = 1;
    end else if (op == 9) begin
      a1 = 4'(rs); wr = 1; uses[rs] = 1; uses[rd] = 1;
    end else if (op == 10 || op == 11) begin
      a1 = 4'(rd); a2 = 4'(rs); uses[rd] = 1; uses[rs] = 1;
      if (op == 11) imm = (i8 >= 128) ? 16'(i8 + 65536 - 256) : 16'(i8);
    end else if (op == 12) begin
      imm = 16'(rd * 256 + i8);
    end else if (op >= 13) begin
      ill = 1;
    end
  endfunction

  function automatic bit model_ready();
    bit wr, ill;
    logic [3:0] a1, a2;
    logic [15:0] imm, uses;
    spec(in_instr, wr, ill, a1, a2, imm, uses);
    return !reset && (!exp_valid || out_ready) && !flush && !(SbOn && ((pend & uses) != 0));
  endfunction

  always @(posedge clock) begin : model
    bit wr, ill, acc;
    logic [3:0] a1, a2;
    logic [15:0] imm, uses;
    bit [15:0] nxt;
    spec(in_instr, wr, ill, a1, a2, imm, uses);
    acc = in_valid && model_ready();
    if (reset) begin
      exp_valid <= 0; exp_rw <= 0; exp_ill <= 0;
      exp_wreg <= 0; exp_op <= 0; exp_imm <= 0; pend <= '0;
    end else begin
      exp_ill <= acc && ill;
      nxt = pend;
      if (wb_valid) nxt[wb_reg] = 0;
      if (flush && exp_valid && exp_rw) nxt[exp_wreg] = 0;
      if (acc && wr) nxt[in_instr[11:8]] = 1;
      pend <= nxt;
      if (flush) exp_valid <= 0;
      else if (acc) begin
        exp_valid <= 1; exp_rw <= wr; exp_wreg <= in_instr[11:8];
        exp_op <= in_instr[15:12]; exp_imm <= imm;
      end else if (out_ready) exp_valid <= 0;
    end
  end

  always @(negedge clock) begin : compare
    bit wr, ill;
    logic [3:0] a1, a2;
    logic [15:0] imm, uses;
    if (chk_en) begin
      spec(in_instr, wr, ill, a1, a2, imm, uses);
      chk("m_in_ready", in_ready, model_ready());
      chk("m_readReg1", readReg1, a1);
      chk("m_readReg2", readReg2, a2);
      chk("m_out_valid", out_valid, exp_valid);
      chk("m_illegal", illegal, exp_ill);
      if (exp_valid) begin
        chk("m_writeReg", writeReg, exp_wreg);
        chk("m_out_reg_write", out_reg_write, exp_rw);
        chk("m_out_opcode", out_opcode, exp_op);
        chk("m_out_imm", out_imm, exp_imm);
      end
    end
  end

  task automatic cyc();
    @(posedge clock);
    #1;
  endtask

  task automatic settle();
    #3;
  endtask

  task automatic drive(input bit v, input logic [15:0] ins, input bit ordy, input bit fl,
                       input bit wbv, input logic [3:0] wbr);
    in_valid = v; in_instr = ins; out_ready = ordy; flush = fl; wb_valid = wbv; wb_reg = wbr;
  endtask

  task automatic do_reset();
    cyc();
    reset = 1'b1;
    drive(1, 16'h1123, 1, 0, 0, 0);
    settle();
    chk("reset_in_ready", in_ready, 0);
    cyc();
    reset = 1'b0;
    drive(0, 16'h0, 1, 0, 0, 0);
  endtask

  initial begin
    cyc();
    chk_en = 1'b1;

    // Reset state and first decode
    do_reset();
    settle();
    chk("rst_out_valid", out_valid, 0);
    chk("rst_writeReg", writeReg, 0);
    chk("rst_out_imm", out_imm, 0);
    chk("rst_out_opcode", out_opcode, 0);
    chk("rst_reg_write", out_reg_write, 0);
    chk("rst_illegal", illegal, 0);
    drive(1, 16'h1123, 1, 0, 0, 0);
    settle();
    chk("alu_readReg1", readReg1, 2);
    chk("alu_readReg2", readReg2, 3);
    chk("alu_in_ready", in_ready, 1);
    cyc();
    drive(0, 16'h0, 1, 0, 0, 0);
    settle();
    chk("alu_out_valid", out_valid, 1);
    chk("alu_writeReg", writeReg, 1);
    chk("alu_reg_write", out_reg_write, 1);
    chk("alu_opcode", out_opcode, 1);

    // RAW stall released by writeback
    do_reset();
    drive(1, 16'h8105, 1, 0, 0, 0);
    settle();
    chk("raw_first_ready", in_ready, 1);
    cyc();
    drive(1, 16'h1213, 1, 0, 0, 0);
    settle();
    chk("raw_loadi_imm", out_imm, 16'h0005);
    chk("raw_stall1", in_ready, !SbOn);
    cyc();
    settle();
    chk("raw_stall2", in_ready, !SbOn);
    cyc();
    drive(1, 16'h1213, 1, 0, 1, 1);
    settle();
    chk("raw_wb_cycle", in_ready, !SbOn);
    cyc();
    drive(1, 16'h1213, 1, 0, 0, 0);
    settle();
    chk("raw_released", in_ready, 1);
    cyc();
    drive(0, 16'h0, 1, 0, 0, 0);
    settle();
    chk("raw_out_valid", out_valid, 1);
    chk("raw_writeReg", writeReg, 2);

    // Backpressure holds outputs
    do_reset();
    drive(1, 16'h8AFF, 0, 0, 0, 0);
    settle();
    chk("bp_first_ready", in_ready, 1);
    cyc();
    drive(1, 16'h0000, 0, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("bp_out_valid", out_valid, 1);
      chk("bp_out_imm", out_imm, 16'h00FF);
      chk("bp_writeReg", writeReg, 4'hA);
      chk("bp_in_ready", in_ready, 0);
      cyc();
    end
    drive(1, 16'h0000, 1, 0, 0, 0);
    settle();
    chk("bp_release_ready", in_ready, 1);
    cyc();
    drive(0, 16'h0, 1, 0, 0, 0);
    settle();
    chk("bp_nop_valid", out_valid, 1);
    chk("bp_nop_reg_write", out_reg_write, 0);

    // BEQ sign extension
    do_reset();
    drive(1, 16'hBFF8, 1, 0, 0, 0);
    settle();
    chk("beq_readReg1", readReg1, 15);
    chk("beq_readReg2", readReg2, 15);
    cyc();
    drive(0, 16'h0, 1, 0, 0, 0);
    settle();
    chk("beq_imm", out_imm, 16'hFFF8);
    chk("beq_reg_write", out_reg_write, 0);

    // Illegal pulse, then flush of a held writer
    do_reset();
    drive(1, 16'hE000, 1, 0, 0, 0);
    cyc();
    drive(1, 16'h8300, 1, 0, 0, 0);
    settle();
    chk("ill_pulse", illegal, 1);
    chk("ill_reg_write", out_reg_write, 0);
    cyc();
    drive(0, 16'h0, 0, 1, 0, 0);
    settle();
    chk("ill_pulse_end", illegal, 0);
    chk("fl_held_wreg", writeReg, 3);
    chk("fl_in_ready", in_ready, 0);
    cyc();
    drive(1, 16'h1330, 1, 0, 0, 0);
    settle();
    chk("fl_out_valid", out_valid, 0);
    chk("fl_bit3_clear", in_ready, 1);

    // Reset during a stall
    do_reset();
    drive(1, 16'h8105, 1, 0, 0, 0);
    cyc();
    drive(1, 16'h1213, 1, 0, 0, 0);
    settle();
    chk("rs_stall", in_ready, !SbOn);
    cyc();
    reset = 1'b1;
    settle();
    chk("rs_in_ready", in_ready, 0);
    cyc();
    reset = 1'b0;
    settle();
    chk("rs_out_valid", out_valid, 0);
    chk("rs_hazard_gone", in_ready, 1);

    // Randomized traffic on a small register set to provoke hazards
    for (int n = 0; n < 4000; n++) begin
      cyc();
      reset     = ($urandom_range(0, 299) == 0);
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 24) == 0);
      wb_valid  = ($urandom_range(0, 2) == 0);
      wb_reg    = 4'($urandom_range(0, 3));
      if ($urandom_range(0, 7) == 0) in_instr = 16'($urandom);
      else in_instr = {4'($urandom_range(0, 15)), 4'($urandom_range(0, 3)),
                       4'($urandom_range(0, 3)), 4'($urandom_range(0, 3))};
    end

    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
    $finish;
  end

endmodule
